// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: latches a pattern on start and shifts it out MSB-first,
// repeated reps times with gap idle cycles between repetitions; all outputs registered.
module seq_pattern_tx #(
   parameter int PAT_W = 4,
   parameter int CNT_W = 4,
   parameter int GAP_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [PAT_W-1:0] pattern,
   input  logic [CNT_W-1:0] reps,
   input  logic [GAP_W-1:0] gap,
   output logic             x,
   output logic             x_valid,
   output logic             busy,
   output logic             done
);

   localparam int IDX_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
   localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

   state_t           state_q, state_d;
   logic [PAT_W-1:0] pat_q, pat_d;
   logic [CNT_W-1:0] reps_q, reps_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [GAP_W-1:0] gcnt_q, gcnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             x_d, x_valid_d, busy_d, done_d;
   logic [IDX_W-1:0] idx_m1;
   logic             accept;

   assign idx_m1 = idx_q - IDX_W'(1);
   assign accept = start && !abort && (state_q == IDLE || state_q == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         pat_q   <= '0;
         reps_q  <= '0;
         gap_q   <= '0;
         gcnt_q  <= '0;
         idx_q   <= '0;
         x       <= 1'b0;
         x_valid <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         reps_q  <= reps_d;
         gap_q   <= gap_d;
         gcnt_q  <= gcnt_d;
         idx_q   <= idx_d;
         x       <= x_d;
         x_valid <= x_valid_d;
         busy    <= busy_d;
         done    <= done_d;
      end
   end

   // Next-state logic computes the values the outputs will hold in the next cycle.
   always_comb begin
      state_d   = state_q;
      pat_d     = pat_q;
      reps_d    = reps_q;
      gap_d     = gap_q;
      gcnt_d    = gcnt_q;
      idx_d     = idx_q;
      x_d       = 1'b0;
      x_valid_d = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (accept) begin
               pat_d  = pattern;
               reps_d = reps;
               gap_d  = gap;
               if (reps != '0) begin
                  state_d   = SHIFT;
                  idx_d     = IDX_MSB;
                  x_d       = pattern[PAT_W-1];
                  x_valid_d = 1'b1;
                  busy_d    = 1'b1;
               end else begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end
            end
         end
         SHIFT: begin
            busy_d = 1'b1;
            if (idx_q != '0) begin
               idx_d     = idx_m1;
               x_d       = pat_q[idx_m1];
               x_valid_d = 1'b1;
            end else begin
               // Last bit of a repetition: count it off and decide what follows.
               reps_d = reps_q - CNT_W'(1);
               if (reps_q == CNT_W'(1)) begin
                  state_d = DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else if (gap_q == '0) begin
                  idx_d     = IDX_MSB;
                  x_d       = pat_q[PAT_W-1];
                  x_valid_d = 1'b1;
               end else begin
                  state_d = GAP;
                  gcnt_d  = gap_q;
               end
            end
         end
         GAP: begin
            busy_d = 1'b1;
            if (gcnt_q <= GAP_W'(1)) begin
               state_d   = SHIFT;
               gcnt_d    = '0;
               idx_d     = IDX_MSB;
               x_d       = pat_q[PAT_W-1];
               x_valid_d = 1'b1;
            end else begin
               gcnt_d = gcnt_q - GAP_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      if (abort) begin
         state_d   = IDLE;
         x_d       = 1'b0;
         x_valid_d = 1'b0;
         busy_d    = 1'b0;
         done_d    = 1'b0;
      end
   end

endmodule
